// File: rtl/vga_lane_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_lane_decoder
// Brief    : Recovers pixel position from VGA syncs and rebuilds the 8x8 lane
//            occupancy map from cell-centre samples, publishing clean frames.
// Revision : 1.0
// ============================================================================
module vga_lane_decoder #(
    parameter int         H_BACK   = 49,
    parameter int         H_ACTIVE = 640,
    parameter int         V_BACK   = 34,
    parameter int         V_ACTIVE = 480,
    parameter int         CELL_W   = 80,
    parameter int         CELL_H   = 60,
    parameter logic [2:0] ON_COLOR = 3'b100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic [2:0]  pixel,
    output logic [63:0] rows,
    output logic        frame_valid,
    output logic        frame_drop,
    output logic        lock
);
    localparam int c_cw = $clog2(CELL_W + 1);
    localparam int c_rw = $clog2(CELL_H + 1);

    localparam logic [c_cw-1:0] c_col_mid    = c_cw'(CELL_W / 2);
    localparam logic [c_cw-1:0] c_col_last   = c_cw'(CELL_W - 1);
    localparam logic [c_rw-1:0] c_row_mid    = c_rw'(CELL_H / 2);
    localparam logic [c_rw-1:0] c_row_last   = c_rw'(CELL_H - 1);
    localparam logic [9:0]      c_hback_last = 10'(H_BACK - 1);
    localparam logic [9:0]      c_h_last     = 10'(H_ACTIVE - 1);
    localparam logic [9:0]      c_vback      = 10'(V_BACK);
    localparam logic [9:0]      c_v_last     = 10'(V_ACTIVE - 1);
    localparam logic [9:0]      c_v_active   = 10'(V_ACTIVE);
    localparam logic [9:0]      c_cnt10_max  = 10'h3FF;
    localparam logic [10:0]     c_cnt11_max  = 11'h7FF;

    typedef enum logic [1:0] {
        HS_SYNC   = 2'd0,
        HS_BACK   = 2'd1,
        HS_ACTIVE = 2'd2,
        HS_FRONT  = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        VS_SYNC   = 2'd0,
        VS_BACK   = 2'd1,
        VS_ACTIVE = 2'd2,
        VS_FRONT  = 2'd3
    } v_state_t;

    h_state_t        r_h_state;
    v_state_t        r_v_state;
    logic            r_hs_d, r_vs_d;
    logic [9:0]      r_hcnt, r_x, r_lcnt, r_y, r_line_cnt;
    logic [c_cw-1:0] r_col_sub;
    logic [c_rw-1:0] r_row_sub;
    logic [2:0]      r_col_idx, r_row_idx;
    logic [63:0]     r_shadow;
    logic [10:0]     r_pcnt, r_period;
    logic            r_have_ref, r_have_period;
    logic            r_frame_err, r_armed;

    logic            w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
    logic [9:0]      w_hcnt_inc, w_lcnt_inc, w_line_cnt_nxt;
    logic            w_period_bad, w_short, w_err_nxt, w_frame_ok, w_sample;
    logic [5:0]      w_bit_idx;

    assign w_hs_fall  = pix_ce &  r_hs_d & ~hsync_n;
    assign w_hs_rise  = pix_ce & ~r_hs_d &  hsync_n;
    assign w_vs_fall  = pix_ce &  r_vs_d & ~vsync_n;
    assign w_vs_rise  = pix_ce & ~r_vs_d &  vsync_n;

    assign w_hcnt_inc = (r_hcnt == c_cnt10_max) ? r_hcnt : r_hcnt + 10'd1;
    assign w_lcnt_inc = (r_lcnt == c_cnt10_max) ? r_lcnt : r_lcnt + 10'd1;

    // Line-end effects are folded in combinationally so a coincident
    // vsync fall closes the frame with the finished line already counted.
    assign w_period_bad   = w_hs_fall & r_have_period & (r_pcnt != r_period);
    assign w_short        = w_hs_fall & (r_h_state == HS_ACTIVE);
    assign w_err_nxt      = r_frame_err | w_period_bad | w_short;
    assign w_line_cnt_nxt = (w_hs_fall && r_v_state == VS_ACTIVE && r_line_cnt != c_cnt10_max)
                            ? r_line_cnt + 10'd1 : r_line_cnt;
    assign w_frame_ok     = !w_err_nxt && (w_line_cnt_nxt == c_v_active)
                            && (w_line_cnt_nxt != c_cnt10_max);

    assign w_sample  = pix_ce && r_h_state == HS_ACTIVE && r_v_state == VS_ACTIVE
                       && r_col_sub == c_col_mid && r_row_sub == c_row_mid;
    // Bit 8*row + 7 - col; for a 3-bit column, 7 - col is its complement.
    assign w_bit_idx = {r_row_idx, ~r_col_idx};

    // Horizontal tracking. H_BACK is assumed to be at least 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_d    <= 1'b1;
            r_h_state <= HS_FRONT;
            r_hcnt    <= '0;
            r_x       <= '0;
            r_col_sub <= '0;
            r_col_idx <= '0;
        end else if (pix_ce) begin
            r_hs_d <= hsync_n;
            if (w_hs_fall) begin
                r_h_state <= HS_SYNC;
            end else if (w_hs_rise) begin
                r_h_state <= HS_BACK;
                r_hcnt    <= '0;
            end else begin
                case (r_h_state)
                    HS_BACK: begin
                        if (w_hcnt_inc == c_hback_last) begin
                            r_h_state <= HS_ACTIVE;
                            r_x       <= '0;
                            r_col_sub <= '0;
                            r_col_idx <= '0;
                        end else begin
                            r_hcnt <= w_hcnt_inc;
                        end
                    end
                    HS_ACTIVE: begin
                        if (r_x == c_h_last) begin
                            r_h_state <= HS_FRONT;
                        end else begin
                            r_x <= r_x + 10'd1;
                            if (r_col_sub == c_col_last) begin
                                r_col_sub <= '0;
                                r_col_idx <= r_col_idx + 3'd1;
                            end else begin
                                r_col_sub <= r_col_sub + c_cw'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Vertical tracking, advanced by hsync falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_d    <= 1'b1;
            r_v_state <= VS_FRONT;
            r_lcnt    <= '0;
            r_y       <= '0;
            r_row_sub <= '0;
            r_row_idx <= '0;
        end else if (pix_ce) begin
            r_vs_d <= vsync_n;
            if (w_vs_fall) begin
                r_v_state <= VS_SYNC;
            end else if (w_vs_rise) begin
                r_v_state <= VS_BACK;
                r_lcnt    <= '0;
            end else if (w_hs_fall) begin
                case (r_v_state)
                    VS_BACK: begin
                        if (w_lcnt_inc == c_vback) begin
                            r_v_state <= VS_ACTIVE;
                            r_y       <= '0;
                            r_row_sub <= '0;
                            r_row_idx <= '0;
                        end else begin
                            r_lcnt <= w_lcnt_inc;
                        end
                    end
                    VS_ACTIVE: begin
                        if (r_y == c_v_last) begin
                            r_v_state <= VS_FRONT;
                        end else begin
                            r_y <= r_y + 10'd1;
                            if (r_row_sub == c_row_last) begin
                                r_row_sub <= '0;
                                r_row_idx <= r_row_idx + 3'd1;
                            end else begin
                                r_row_sub <= r_row_sub + c_rw'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sampling, line-period check and frame publication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow      <= '0;
            r_pcnt        <= '0;
            r_period      <= '0;
            r_have_ref    <= 1'b0;
            r_have_period <= 1'b0;
            r_frame_err   <= 1'b0;
            r_line_cnt    <= '0;
            r_armed       <= 1'b0;
            rows          <= '0;
            frame_valid   <= 1'b0;
            frame_drop    <= 1'b0;
            lock          <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_drop  <= 1'b0;
            if (pix_ce) begin
                if (w_sample) begin
                    r_shadow[w_bit_idx] <= (pixel == ON_COLOR);
                end

                if (w_hs_fall) begin
                    r_pcnt     <= 11'd1;
                    r_have_ref <= 1'b1;
                    if (r_have_ref) begin
                        r_period      <= r_pcnt;
                        r_have_period <= 1'b1;
                    end
                end else if (r_pcnt != c_cnt11_max) begin
                    r_pcnt <= r_pcnt + 11'd1;
                end

                if (w_vs_fall) begin
                    r_frame_err <= 1'b0;
                    r_line_cnt  <= '0;
                    if (!r_armed) begin
                        r_armed <= 1'b1;
                    end else if (w_frame_ok) begin
                        rows        <= r_shadow;
                        frame_valid <= 1'b1;
                        lock        <= 1'b1;
                    end else begin
                        frame_drop    <= 1'b1;
                        lock          <= 1'b0;
                        r_have_period <= 1'b0;
                    end
                end else begin
                    r_frame_err <= w_err_nxt;
                    r_line_cnt  <= w_line_cnt_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vga_lane_decoder.md
# vga_lane_decoder

Receive-side counterpart of the VGA pixel writer. Consumes the active-low hsync/vsync and 3-bit pixel stream, recovers the horizontal and vertical position from sync edges, and samples the centre of every 80x60 cell to rebuild the 8x8 lane occupancy map. Each completed, error-free frame is published to the checker and scoreboard logic of the game display path.

## Interface
Parameters:
- H_BACK, 49: pix_ce ticks from hsync_n rising edge to the first active pixel (x=0).
- H_ACTIVE, 640: active pixels per line.
- V_BACK, 34: hsync_n falling edges from vsync_n rising edge to the first active line (y=0).
- V_ACTIVE, 480: active lines per frame.
- CELL_W, 80: cell width in pixels.
- CELL_H, 60: cell height in lines.
- ON_COLOR, 3'b100: pixel value decoded as an occupied cell.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- pix_ce, input, 1: pixel-rate enable; all decoding advances only on cycles where pix_ce=1.
- hsync_n, input, 1: horizontal sync, active low, synchronous to clk.
- vsync_n, input, 1: vertical sync, active low, synchronous to clk.
- pixel, input, 3: RGB pixel.
- rows, output, 64: rows[8r+7:8r] = row r (r=0 top); bit 7 = leftmost cell.
- frame_valid, output, 1: one-clk pulse when rows updates.
- frame_drop, output, 1: one-clk pulse when a frame is discarded.
- lock, output, 1: decoder is tracking a stable stream.

## Operation
- Edge detect: hs_d and vs_d register hsync_n and vsync_n on pix_ce. A falling edge is d=1 and now=0.
- Horizontal FSM states: H_SYNC, H_BACK, H_ACTIVE, H_FRONT.
  - hsync_n fall -> H_SYNC.
  - hsync_n rise -> H_BACK and load hcnt=0.
  - When hcnt reaches H_BACK-1 -> H_ACTIVE with x=0.
  - When x reaches H_ACTIVE-1 -> H_FRONT.
- Vertical FSM states: V_SYNC, V_BACK, V_ACTIVE, V_FRONT.
  - vsync_n fall -> V_SYNC.
  - vsync_n rise -> V_BACK with lcnt=0. lcnt increments on each hsync_n fall.
  - lcnt==V_BACK -> V_ACTIVE with y=0. y increments on each hsync_n fall.
  - After V_ACTIVE lines -> V_FRONT.
- Sampling: in H_ACTIVE and V_ACTIVE, when x mod CELL_W == CELL_W/2 and y mod CELL_H == CELL_H/2:
  - write shadow bit [row=y/CELL_H][7 - x/CELL_W] = (pixel == ON_COLOR).
  - Use running column and row sub-counters; no dividers.
- Line-length check: count pix_ce ticks between consecutive hsync_n falls (11-bit, saturating at 2047). A period differing from the previous period sets frame_err. The first period after reset or after a drop only records and is never compared.
- Frame close, on vsync_n fall:
  - if frame_err==0 and exactly V_ACTIVE active lines were seen: rows <= shadow, frame_valid=1, lock=1.
  - otherwise: frame_drop=1, lock=0, rows unchanged.
  - In both cases clear frame_err and the line counter.
- First vsync_n fall after reset only arms the decoder: no frame_valid, no frame_drop.
- hsync_n fall while in H_ACTIVE (short line) sets frame_err.
- vsync_n fall during V_ACTIVE closes the frame with a line-count mismatch, which gives a drop.

## Timing
- Reset values: rows=0, frame_valid=0, frame_drop=0, lock=0, both FSMs idle in H_FRONT/V_FRONT, frame_err=0, armed=0.
- Reset mid-frame discards the shadow; the next vsync_n fall only re-arms.
- Sampling latency: pixel is sampled on the same pix_ce cycle its x/y is current.
- rows, frame_valid, frame_drop and lock all update on the clk edge after the pix_ce cycle that detects the vsync_n fall.
- frame_valid and frame_drop are mutually exclusive and exactly one clk wide, even when pix_ce stays high.
- With pix_ce=0, all state holds and the inputs are ignored.
- Simultaneous hsync_n and vsync_n falls: process the line end first, then the frame close.
- Counters wrap never: hcnt and x saturate; the line counter saturates at 1023 and saturation forces a drop.

## Test plan
- Reset, then two clean 801x526 frames (pix_ce every 4th clk) with pixel=3'b100 only in cells (1,0) and (6,7) -> after frame 2: frame_valid once, rows[15:8]=8'h80, rows[55:48]=8'h01, all other bytes 0, lock=1.
- Stream the game's row pattern 8'b0111_0111 on row 1, with one pixel 3'b100 placed 1 pixel off-centre in a black cell -> rows[15:8]=8'h77 (only centre samples count).
- One line shortened to 790 ticks mid-frame -> frame_drop pulse at the next vsync fall, lock=0, rows retains the previous value; the next clean frame -> frame_valid, lock=1.
- vsync_n fall after 300 active lines -> frame_drop, no rows update.
- Assert reset during active line 200 -> all outputs 0 immediately; the first following vsync fall produces no pulse, and the second produces frame_valid.
- Hold pix_ce=0 for 1000 clks mid-line, then resume -> decoded rows identical to the uninterrupted run.
